rf_write_arbiter: RTL and testbench

//  Shares the register file's single write port among NUM_REQ writeback sources (ALU, load, MAC, ...).

---
 rtl/rf_write_arbiter_pkg.sv | 20 ++
 rtl/rf_write_arbiter_if.sv | 33 +++
 rtl/rf_write_arbiter_rr_pick.sv | 35 +++
 rtl/rf_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: widths,
// FSM state encoding and a small index helper.
package rf_write_arbiter_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 16;
    localparam int REG_DEPTH  = 32'sd1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SINGLE = 2'd1,
        ARB_BURST  = 2'd2
    } arb_state_e;

    // Next requester index after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 32'sd1) % n;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester-side handshake and register-file write port of the arbiter.
// The arbiter uses the slave modport; the requesters/regfile side uses master.
interface rf_write_arbiter_if
    import rf_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_WIDTH,
    parameter int DATA_W  = DATA_WIDTH
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      hold;
    logic                      rf_write_en;
    logic [ADDR_W-1:0]         rf_write_addr;
    logic [DATA_W-1:0]         rf_write_data;
    logic [IDX_W-1:0]          grant_id;

    modport slave (
        input  req_valid, req_lock, req_addr, req_data, hold,
        output req_ready, rf_write_en, rf_write_addr, rf_write_data, grant_id
    );

    modport master (
        output req_valid, req_lock, req_addr, req_data, hold,
        input  req_ready, rf_write_en, rf_write_addr, rf_write_data, grant_id
    );

endinterface

// File: rtl/rf_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping modulo NUM_REQ. Returns a one-hot grant, its index and a hit flag.
module rf_write_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Walk the requesters in priority order starting at ptr; first hit wins
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_s  = IDX_W'((int'(ptr) + off) % NUM_REQ);
            hit_s   = !gnt_any && req[cand_s];
            gnt_oh  = hit_s ? (ONE_HOT0 << cand_s) : gnt_oh;
            gnt_idx = hit_s ? cand_s : gnt_idx;
            gnt_any = gnt_any || hit_s;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port, with
// capped locked bursts and a registered write stage (one cycle of latency).
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = ADDR_WIDTH,
    parameter int DATA_W    = DATA_WIDTH,
    parameter int MAX_BURST = 8
) (
    input  logic            clk,
    input  logic            rst,
    rf_write_arbiter_if.slave arb
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0] pick_oh_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_any_s;
    logic               burst_keep_s;
    logic               new_grant_s;
    logic               entry_lock_s;
    logic [NUM_REQ-1:0] ready_s;

    rf_write_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (arb.req_valid),
        .ptr     (rr_ptr_q),
        .gnt_oh  (pick_oh_s),
        .gnt_idx (pick_idx_s),
        .gnt_any (pick_any_s)
    );

    // Burst owner keeps the port while it still asks for it and has beats left
    always_comb begin
        burst_keep_s = (state_q == ARB_BURST) && arb.req_valid[owner_q] &&
                       arb.req_lock[owner_q] && (burst_cnt_q < BURST_MAX);
    end

    // FSM output: ready vector; gated during reset so no request is lost
    always_comb begin
        ready_s     = '0;
        new_grant_s = 1'b0;
        if (rst || arb.hold) begin
            ready_s = '0;
        end else if (burst_keep_s) begin
            ready_s[owner_q] = 1'b1;
        end else begin
            ready_s     = pick_oh_s;
            new_grant_s = pick_any_s;
        end
    end

    assign arb.req_ready = ready_s;

    // FSM next state, rotation pointer and burst accounting
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        burst_cnt_d  = burst_cnt_q;
        entry_lock_s = arb.req_lock[pick_idx_s];
        case (state_q)
            ARB_IDLE, ARB_SINGLE: begin
                if (new_grant_s) begin
                    state_d     = entry_lock_s ? ARB_BURST : ARB_SINGLE;
                    owner_d     = pick_idx_s;
                    rr_ptr_d    = IDX_W'(wrap_inc(int'(pick_idx_s), NUM_REQ));
                    burst_cnt_d = entry_lock_s ? CNT_ONE : '0;
                end else begin
                    state_d     = ARB_IDLE;
                    burst_cnt_d = '0;
                end
            end
            ARB_BURST: begin
                if (arb.hold) begin
                    state_d = ARB_BURST;
                end else if (burst_keep_s) begin
                    burst_cnt_d = burst_cnt_q + CNT_ONE;
                end else if (new_grant_s) begin
                    // Burst ended; rr_ptr already sits after the owner, so it re-wins last
                    state_d     = entry_lock_s ? ARB_BURST : ARB_SINGLE;
                    owner_d     = pick_idx_s;
                    rr_ptr_d    = IDX_W'(wrap_inc(int'(pick_idx_s), NUM_REQ));
                    burst_cnt_d = entry_lock_s ? CNT_ONE : '0;
                end else begin
                    state_d     = ARB_IDLE;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Write stage next values: load the granted beat, otherwise keep addr/data
    always_comb begin
        wr_en_d    = |ready_s;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            wr_addr_d  = ready_s[i] ? arb.req_addr[i*ADDR_W +: ADDR_W] : wr_addr_d;
            wr_data_d  = ready_s[i] ? arb.req_data[i*DATA_W +: DATA_W] : wr_data_d;
            grant_id_d = ready_s[i] ? IDX_W'(i) : grant_id_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Registered write port towards the register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
        end else begin
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign arb.rf_write_en   = wr_en_q;
    assign arb.rf_write_addr = wr_addr_q;
    assign arb.rf_write_data = wr_data_q;
    assign arb.grant_id      = grant_id_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus random
// traffic compared against a behavioural arbitration model and regfile image.
module tb_rf_write_arbiter;
    import rf_write_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int MB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    rf_write_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // requester-side stimulus
    bit          v  [N];
    bit          lk [N];
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];
    bit          h;

    // behavioural model: owner<0 means no burst in progress
    int            m_owner;
    int            m_beats;
    int            m_ptr;
    bit            exp_en;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    int            exp_gid;
    int            last_g;
    logic [DW-1:0] model_rf [REG_DEPTH] = '{default: '0};
    logic [DW-1:0] seen_rf  [REG_DEPTH] = '{default: '0};

    // register file stand-in: commits on the falling edge
    always @(negedge clk) begin
        if (bus.rf_write_en === 1'b1) seen_rf[bus.rf_write_addr] <= bus.rf_write_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]            = v[i];
            bus.req_lock[i]             = lk[i];
            bus.req_addr[i*AW +: AW]    = a[i];
            bus.req_data[i*DW +: DW]    = d[i];
        end
        bus.hold = h;
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_beats  = 0;
        m_ptr    = 0;
        exp_en   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_gid  = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_en"},   32'(bus.rf_write_en),   32'(exp_en));
        check_eq({tag, "_addr"}, 32'(bus.rf_write_addr), 32'(exp_addr));
        check_eq({tag, "_data"}, 32'(bus.rf_write_data), 32'(exp_data));
        check_eq({tag, "_gid"},  32'(bus.grant_id),      32'(exp_gid));
    endtask

    // one clock: starts just after a rising edge, ends just after the next
    task automatic cycle();
        int g;
        bit cont;
        logic [N-1:0] er;
        if (exp_en) model_rf[exp_addr] = exp_data;
        drive();
        #1;
        cont = 1'b0;
        if (!h && m_owner >= 0) cont = v[m_owner] && lk[m_owner] && (m_beats < MB);
        g = -1;
        if (cont) g = m_owner;
        else if (!h) begin
            for (int off = 0; off < N; off++) begin
                if (g < 0 && v[(m_ptr + off) % N]) g = (m_ptr + off) % N;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check_eq("req_ready", 32'(bus.req_ready), 32'(er));
        @(posedge clk);
        if (g >= 0) begin
            exp_en   = 1'b1;
            exp_addr = a[g];
            exp_data = d[g];
            exp_gid  = g;
            if (cont) m_beats++;
            else begin
                m_ptr = (g + 1) % N;
                if (lk[g]) begin
                    m_owner = g;
                    m_beats = 1;
                end else begin
                    m_owner = -1;
                    m_beats = 0;
                end
            end
        end else begin
            exp_en = 1'b0;
            if (!h) begin
                m_owner = -1;
                m_beats = 0;
            end
        end
        last_g = g;
        #1;
        check_outputs("beat");
    endtask

    int bseq [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 1};

    initial begin
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; lk[i] = 1'b0; a[i] = '0; d[i] = '0;
        end
        h = 1'b0;
        drive();
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check_eq("reset_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;

        // reset in the middle of a burst from requester 0
        v[0] = 1'b1; lk[0] = 1'b1; a[0] = 5'd3; d[0] = 16'h0303;
        repeat (3) cycle();
        rst = 1'b1;
        #1;
        check_eq("midrst_en",    32'(bus.rf_write_en),   32'd0);
        check_eq("midrst_addr",  32'(bus.rf_write_addr), 32'd0);
        check_eq("midrst_data",  32'(bus.rf_write_data), 32'd0);
        check_eq("midrst_gid",   32'(bus.grant_id),      32'd0);
        check_eq("midrst_ready", 32'(bus.req_ready),     32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // plain round-robin with everyone requesting
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; lk[i] = 1'b0; a[i] = AW'(i); d[i] = DW'(16'h00A0 + i);
        end
        for (int k = 0; k < 8; k++) begin
            cycle();
            check_eq("rr_gid", 32'(bus.grant_id), 32'(k % N));
            check_eq("rr_en",  32'(bus.rf_write_en), 32'd1);
        end

        // burst cap: locked req1 against plain req2
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; lk[i] = 1'b0;
        end
        v[1] = 1'b1; lk[1] = 1'b1; a[1] = 5'd7; d[1] = 16'h1234;
        v[2] = 1'b1; lk[2] = 1'b0; a[2] = 5'd8; d[2] = 16'h5678;
        for (int k = 0; k < 11; k++) begin
            cycle();
            check_eq("burst_gid", 32'(bus.grant_id), 32'(bseq[k]));
        end

        // hold stalls grants, then req0 goes through
        v[1] = 1'b0; lk[1] = 1'b0; v[2] = 1'b0;
        v[0] = 1'b1; lk[0] = 1'b0; a[0] = 5'd9; d[0] = 16'h9999;
        h = 1'b1;
        repeat (3) begin
            cycle();
            check_eq("hold_en", 32'(bus.rf_write_en), 32'd0);
        end
        h = 1'b0;
        cycle();
        check_eq("release_gid", 32'(bus.grant_id), 32'd0);
        check_eq("release_en",  32'(bus.rf_write_en), 32'd1);
        v[0] = 1'b0;

        // same-address collision with rr_ptr at 3
        v[2] = 1'b1; a[2] = 5'd10; d[2] = 16'h0001;
        cycle();
        v[2] = 1'b0;
        v[0] = 1'b1; a[0] = 5'd5; d[0] = 16'h1111;
        v[3] = 1'b1; a[3] = 5'd5; d[3] = 16'h2222;
        cycle();
        check_eq("coll_first", 32'(bus.grant_id), 32'd3);
        v[3] = 1'b0;
        cycle();
        check_eq("coll_second", 32'(bus.grant_id), 32'd0);
        v[0] = 1'b0;
        cycle();
        check_eq("coll_rf5", 32'(seen_rf[5]), 32'h1111);

        // idle: nothing requested, write port quiet and stage holds
        repeat (3) begin
            cycle();
            check_eq("idle_en",   32'(bus.rf_write_en),   32'd0);
            check_eq("idle_addr", 32'(bus.rf_write_addr), 32'd5);
            check_eq("idle_data", 32'(bus.rf_write_data), 32'h1111);
        end

        // random traffic; requests stay put until granted
        for (int k = 0; k < 3000; k++) begin
            cycle();
            if (last_g >= 0) v[last_g] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 3) != 0) begin
                    v[i] = 1'b1;
                    a[i] = AW'($urandom_range(0, 7));
                    d[i] = DW'($urandom);
                end
                if ($urandom_range(0, 5) == 0) lk[i] = ($urandom_range(0, 2) != 0);
            end
            h = ($urandom_range(0, 7) == 0);
        end

        // drain and compare the register file image
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        h = 1'b0;
        repeat (2) cycle();
        for (int r = 0; r < REG_DEPTH; r++) begin
            check_eq($sformatf("rf_%0d", r), 32'(seen_rf[r]), 32'(model_rf[r]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
